// File: rtl/minisys_pkg.sv
// Shared constants for the minisys IO bridge: IO base byte, register
// offsets (word index addr[7:2]), TCTRL bit positions, byte-lane merge.
package minisys_pkg;

  localparam logic [7:0] IO_BASE    = 8'hff;

  localparam logic [5:0] OFF_LED    = 6'h00;
  localparam logic [5:0] OFF_SEG    = 6'h01;
  localparam logic [5:0] OFF_SW     = 6'h02;
  localparam logic [5:0] OFF_TCTRL  = 6'h03;
  localparam logic [5:0] OFF_TLOAD  = 6'h04;
  localparam logic [5:0] OFF_TCOUNT = 6'h05;

  localparam int TC_EN   = 0;
  localparam int TC_AUTO = 1;
  localparam int TC_STAT = 2;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] i_old,
    input logic [31:0] i_new,
    input logic [3:0]  i_be
  );
    logic [31:0] v;
    v = i_old;
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) v[8*i +: 8] = i_new[8*i +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/minisys_io_timer.sv
// Down-counting timer: TCTRL (EN/AUTO/STAT), TLOAD, TCOUNT, irq = STAT.
// Ports: clk, rst_n, i_ctrl_we/i_ctrl, i_load_be/i_wdata -> o_ctrl/o_load/o_count/o_irq.
module minisys_io_timer
  import minisys_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ctrl_we,
  input  logic [2:0]  i_ctrl,
  input  logic [3:0]  i_load_be,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ctrl,
  output logic [31:0] o_load,
  output logic [31:0] o_count,
  output logic        o_irq
);

  logic        r_en;
  logic        r_auto;
  logic        r_stat;
  logic [31:0] r_load;
  logic [31:0] r_count;

  logic        w_expire;
  logic        w_load_we;
  logic [31:0] w_load_nx;

  // Expiry looks at the registered EN, so setting EN while
  // TCOUNT==0 only expires on the following edge.
  assign w_expire  = r_en && (r_count == '0);
  assign w_load_we = |i_load_be;
  assign w_load_nx = lane_merge(r_load, i_wdata, i_load_be);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_auto  <= 1'b0;
      r_stat  <= 1'b0;
      r_load  <= '0;
      r_count <= '0;
    end else begin
      // A software write to TCTRL overrides the one-shot EN clear.
      if (i_ctrl_we) begin
        r_en   <= i_ctrl[TC_EN];
        r_auto <= i_ctrl[TC_AUTO];
      end else if (w_expire && !r_auto) begin
        r_en <= 1'b0;
      end

      // Expiry beats write-one-to-clear.
      if (w_expire) begin
        r_stat <= 1'b1;
      end else if (i_ctrl_we && i_ctrl[TC_STAT]) begin
        r_stat <= 1'b0;
      end

      if (w_load_we) r_load <= w_load_nx;

      // While running, a reload uses the old TLOAD value.
      if (r_en) begin
        if (!w_expire) begin
          r_count <= r_count - 32'd1;
        end else if (r_auto) begin
          r_count <= r_load;
        end
      end else if (w_load_we) begin
        r_count <= w_load_nx;
      end
    end
  end

  always_comb begin
    o_ctrl          = '0;
    o_ctrl[TC_EN]   = r_en;
    o_ctrl[TC_AUTO] = r_auto;
    o_ctrl[TC_STAT] = r_stat;
  end

  assign o_load  = r_load;
  assign o_count = r_count;
  assign o_irq   = r_stat;

endmodule

// File: rtl/minisys_io_bridge.sv
// MEM-stage IO bridge: LED/SEG/SW registers plus optional timer
// (MINISYS_IO_TIMER_EN). Ports: clk, clrn, addr, wdata, memwrite, sw ->
// io_sel, io_data, led, seg, timer_irq.
module minisys_io_bridge
  import minisys_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  memwrite,
  input  logic [23:0] sw,
  output logic        io_sel,
  output logic [31:0] io_data,
  output logic [23:0] led,
  output logic [31:0] seg,
  output logic        timer_irq
);

  logic [23:0] r_led;
  logic [31:0] r_seg;
  logic [23:0] r_sw_meta;
  logic [23:0] r_sw_sync;

  logic        w_sel;
  logic [5:0]  w_off;
  logic [3:0]  w_we;
  logic        w_hit_led;
  logic        w_hit_seg;
  logic        w_hit_sw;
  logic        w_hit_tctrl;
  logic        w_hit_tload;
  logic        w_hit_tcount;
  logic [31:0] w_tctrl;
  logic [31:0] w_tload;
  logic [31:0] w_tcount;
  logic        w_irq;
  logic        w_unused;

  assign w_sel = (addr[31:24] == IO_BASE);
  assign w_off = addr[7:2];
  assign w_we  = w_sel ? memwrite : 4'b0000;

  assign w_hit_led    = w_sel && (w_off == OFF_LED);
  assign w_hit_seg    = w_sel && (w_off == OFF_SEG);
  assign w_hit_sw     = w_sel && (w_off == OFF_SW);
  assign w_hit_tctrl  = w_sel && (w_off == OFF_TCTRL);
  assign w_hit_tload  = w_sel && (w_off == OFF_TLOAD);
  assign w_hit_tcount = w_sel && (w_off == OFF_TCOUNT);

  assign w_unused = ^{addr[23:8], addr[1:0]};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_led <= '0;
      r_seg <= '0;
    end else begin
      if (w_hit_led) begin
        for (int i = 0; i < 3; i++) begin
          if (w_we[i]) r_led[8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      if (w_hit_seg && |w_we) begin
        r_seg <= lane_merge(r_seg, wdata, w_we);
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

`ifdef MINISYS_IO_TIMER_EN
  minisys_io_timer u_timer (
    .clk       (clk),
    .rst_n     (clrn),
    .i_ctrl_we (w_hit_tctrl && w_we[0]),
    .i_ctrl    (wdata[2:0]),
    .i_load_be (w_hit_tload ? w_we : 4'b0000),
    .i_wdata   (wdata),
    .o_ctrl    (w_tctrl),
    .o_load    (w_tload),
    .o_count   (w_tcount),
    .o_irq     (w_irq)
  );
`else
  assign w_tctrl  = '0;
  assign w_tload  = '0;
  assign w_tcount = '0;
  assign w_irq    = 1'b0;
`endif

  always_comb begin
    io_data = '0;
    unique case (1'b1)
      w_hit_led:    io_data = {8'd0, r_led};
      w_hit_seg:    io_data = r_seg;
      w_hit_sw:     io_data = {8'd0, r_sw_sync};
      w_hit_tctrl:  io_data = w_tctrl;
      w_hit_tload:  io_data = w_tload;
      w_hit_tcount: io_data = w_tcount;
      default:      io_data = '0;
    endcase
  end

  assign io_sel    = w_sel;
  assign led       = r_led;
  assign seg       = r_seg;
  assign timer_irq = w_irq;

endmodule

// File: tb/tb_minisys_io_bridge.sv
// Testbench for minisys_io_bridge: directed cases plus random traffic
// against a register-map level reference model (timer if MINISYS_IO_TIMER_EN).
module tb_minisys_io_bridge;

`ifdef MINISYS_IO_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  memwrite;
  logic [23:0] sw;
  logic        io_sel;
  logic [31:0] io_data;
  logic [23:0] led;
  logic [31:0] seg;
  logic        timer_irq;

  minisys_io_bridge dut (
    .clk       (clk),
    .clrn      (clrn),
    .addr      (addr),
    .wdata     (wdata),
    .memwrite  (memwrite),
    .sw        (sw),
    .io_sel    (io_sel),
    .io_data   (io_data),
    .led       (led),
    .seg       (seg),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [23:0] m_led, m_sw1, m_sw2, cur_sw;
  logic [31:0] m_seg, m_load, m_count, rdata;
  logic        m_en, m_auto, m_stat;

  task automatic m_reset();
    m_led = 0; m_seg = 0; m_sw1 = 0; m_sw2 = 0;
    m_en = 0; m_auto = 0; m_stat = 0; m_load = 0; m_count = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [7:0] off;
    if (a[31:24] != 8'hff) return 32'd0;
    off = {a[7:2], 2'b00};
    case (off)
      8'h00: return {8'd0, m_led};
      8'h04: return m_seg;
      8'h08: return {8'd0, m_sw2};
      8'h0c: return TMR ? {29'd0, m_stat, m_auto, m_en} : 32'd0;
      8'h10: return TMR ? m_load : 32'd0;
      8'h14: return TMR ? m_count : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_edge(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] we, input logic [23:0] s);
    logic io, expire, ne, na, ns;
    logic [7:0] off;
    logic [31:0] nl, nc;
    io  = (a[31:24] == 8'hff);
    off = {a[7:2], 2'b00};
    if (TMR) begin
      expire = m_en && (m_count == 0);
      nl = m_load;
      if (io && off == 8'h10)
        for (int b = 0; b < 4; b++) if (we[b]) nl[8*b +: 8] = d[8*b +: 8];
      nc = m_count;
      if (m_en) nc = expire ? (m_auto ? m_load : 32'd0) : m_count - 1;
      else if (io && off == 8'h10 && we != 0) nc = nl;
      ns = m_stat;
      if (io && off == 8'h0c && we[0] && d[2]) ns = 1'b0;
      if (expire) ns = 1'b1;
      ne = m_en; na = m_auto;
      if (expire && !m_auto) ne = 1'b0;
      if (io && off == 8'h0c && we[0]) begin ne = d[0]; na = d[1]; end
      m_en = ne; m_auto = na; m_stat = ns; m_load = nl; m_count = nc;
    end
    if (io && off == 8'h00)
      for (int b = 0; b < 3; b++) if (we[b]) m_led[8*b +: 8] = d[8*b +: 8];
    if (io && off == 8'h04)
      for (int b = 0; b < 4; b++) if (we[b]) m_seg[8*b +: 8] = d[8*b +: 8];
    m_sw2 = m_sw1;
    m_sw1 = s;
  endtask

  // One bus cycle; entered and left just after a rising edge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] we);
    addr = a; wdata = d; memwrite = we; sw = cur_sw;
    @(negedge clk);
    rdata = io_data;
    chk("io_sel", {31'd0, io_sel}, {31'd0, a[31:24] == 8'hff});
    chk("io_data", io_data, m_read(a));
    @(posedge clk);
    m_edge(a, d, we, cur_sw);
    #1;
    chk("led", {8'd0, led}, {8'd0, m_led});
    chk("seg", seg, m_seg);
    chk("irq", {31'd0, timer_irq}, {31'd0, m_stat});
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(a, 32'd0, 4'b0000);
  endtask

  task automatic pulse_reset();
    addr = 32'hff000014; memwrite = 0;
    clrn = 1'b0;
    #1;
    chk("rst_led", {8'd0, led}, 32'd0);
    chk("rst_seg", seg, 32'd0);
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    chk("rst_cnt", io_data, 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    clrn = 1'b1;
  endtask

  logic [7:0]  top;
  logic [5:0]  off6;
  logic [31:0] ra, rdd;
  logic [3:0]  rwe;

  initial begin
    clrn = 1'b0; addr = 32'hff000008; wdata = 0; memwrite = 0;
    sw = 0; cur_sw = 0;
    m_reset();
    #2;
    chk("rst0_led", {8'd0, led}, 32'd0);
    chk("rst0_seg", seg, 32'd0);
    chk("rst0_irq", {31'd0, timer_irq}, 32'd0);
    chk("rst0_sw", io_data, 32'd0);
    @(posedge clk);
    #1;
    clrn = 1'b1;

    // LED write, ignored non-IO write
    cyc(32'hff000000, 32'h00a5a5a5, 4'b1111);
    chk("led_wr", {8'd0, led}, 32'h00a5a5a5);
    cyc(32'h00000000, 32'h00123456, 4'b1111);
    chk("led_noio", {8'd0, led}, 32'h00a5a5a5);
    chk("iosel_0", {31'd0, io_sel}, 32'd0);

    // SEG byte-lane write
    cyc(32'hff000004, 32'h12345678, 4'b1111);
    cyc(32'hff000004, 32'hffffffff, 4'b0010);
    chk("seg_lane", seg, 32'h1234ff78);

    // SW synchronizer latency
    cur_sw = 24'h00f00f;
    rd(32'hff000008); chk("sw_e0", rdata, 32'd0);
    rd(32'hff000008); chk("sw_e1", rdata, 32'd0);
    rd(32'hff000008); chk("sw_e2", rdata, 32'h0000f00f);

`ifdef MINISYS_IO_TIMER_EN
    // One-shot
    cyc(32'hff000010, 32'd3, 4'b1111);
    cyc(32'hff00000c, 32'd1, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      rd(32'hff000014);
      chk("os_cnt", rdata, 32'(3 - i));
    end
    chk("os_irq", {31'd0, timer_irq}, 32'd1);
    rd(32'hff00000c); chk("os_ctrl", rdata, 32'h4);
    // Auto reload
    cyc(32'hff000010, 32'd3, 4'b1111);
    cyc(32'hff00000c, 32'd7, 4'b0001);
    chk("au_clr", {31'd0, timer_irq}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(32'hff000014);
      chk("au_cnt", rdata, 32'(3 - i));
    end
    chk("au_irq", {31'd0, timer_irq}, 32'd1);
    rd(32'hff000014); chk("au_rld", rdata, 32'd3);
    rd(32'hff000014);
    rd(32'hff000014); chk("au_c1", rdata, 32'd1);
    // W1C on expiry cycle loses, one cycle later wins
    cyc(32'hff00000c, 32'd7, 4'b0001);
    chk("w1c_exp", {31'd0, timer_irq}, 32'd1);
    cyc(32'hff00000c, 32'd7, 4'b0001);
    chk("w1c_late", {31'd0, timer_irq}, 32'd0);
    // Reset mid-count
    cyc(32'hff00000c, 32'd0, 4'b0001);
    cyc(32'hff000010, 32'd4, 4'b1111);
    cyc(32'hff00000c, 32'd1, 4'b0001);
    rd(32'hff000014);
    rd(32'hff000014); chk("mid_c3", rdata, 32'd3);
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      rd(32'hff000014);
      chk("post_cnt", rdata, 32'd0);
      chk("post_irq", {31'd0, timer_irq}, 32'd0);
    end
    // EN set while TCOUNT==0 expires one edge later
    cyc(32'hff00000c, 32'd1, 4'b0001);
    chk("en0_irq", {31'd0, timer_irq}, 32'd0);
    rd(32'hff00000c);
    chk("en0_ctrl", rdata, 32'd1);
    chk("en0_exp", {31'd0, timer_irq}, 32'd1);
`else
    cyc(32'hff00000c, 32'd7, 4'b1111);
    cyc(32'hff000010, 32'd5, 4'b1111);
    rd(32'hff00000c); chk("notmr_ctrl", rdata, 32'd0);
    rd(32'hff000010); chk("notmr_load", rdata, 32'd0);
    chk("notmr_irq", {31'd0, timer_irq}, 32'd0);
    pulse_reset();
    rd(32'hff000000); chk("post_led", rdata, 32'd0);
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        top = 8'($urandom_range(0, 254));
        ra  = {top, 24'($urandom)};
      end else begin
        off6 = 6'($urandom_range(0, 7));
        ra   = {8'hff, 16'($urandom), off6, 2'($urandom)};
      end
      rdd = $urandom;
      if (ra[31:24] == 8'hff && ra[7:2] == 6'h04) rdd = $urandom_range(0, 6);
      rwe = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rwe = 4'b0000;
      if ($urandom_range(0, 15) == 0) cur_sw = 24'($urandom);
      cyc(ra, rdd, rwe);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/minisys_io_bridge.md
MINISYS_IO_BRIDGE -- requirements
Module: minisys_io_bridge

Interface
REQ-001 SHALL have port clk input 1: single system clock; all state updates on rising edge.
REQ-002 SHALL have port clrn input 1: reset, asynchronous, active-low.
REQ-003 SHALL have port addr input 32: MEM-stage byte address (ALU result).
REQ-004 SHALL have port wdata input 32: MEM-stage store data.
REQ-005 SHALL have port memwrite input 4: byte-lane write enables; bit3 -> wdata[31:24] ... bit0 -> wdata[7:0].
REQ-006 SHALL have port sw input 24: asynchronous board switches.
REQ-007 SHALL have port io_sel output 1: high when addr[31:24]==8'hff.
REQ-008 SHALL have port io_data output 32: read data of the selected IO register.
REQ-009 SHALL have port led output 24: LED register contents.
REQ-010 SHALL have port seg output 32: seven-segment data register contents.
REQ-011 SHALL have port timer_irq output 1: timer status bit (level).

Function
REQ-012 SHALL decode the register offset from addr[7:2] only when io_sel=1; register map: 0x00 LED (RW, 24b), 0x04 SEG (RW, 32b), 0x08 SW (RO), 0x0C TCTRL (bit0 EN, bit1 AUTO, bit2 STAT), 0x10 TLOAD (RW, 32b), 0x14 TCOUNT (RO).
REQ-013 SHALL perform writes at the rising clk edge where io_sel=1 and memwrite lane bits are set, updating only the enabled byte lanes; writes with io_sel=0 SHALL be ignored.
REQ-014 SHALL drive io_data combinationally from addr in the same cycle (zero latency); unused bits and unmapped offsets read 0; io_data=0 when io_sel=0.
REQ-015 SHALL pass sw through a two-flop synchronizer; SW reads and no other logic use the second flop.
REQ-016 SHALL ignore writes to SW, TCOUNT and unmapped offsets.
REQ-017 SHALL decrement TCOUNT by 1 per cycle while EN=1 and TCOUNT!=0.
REQ-018 SHALL, on a cycle with EN=1 and TCOUNT==0, set STAT and either reload TCOUNT from TLOAD (AUTO=1) or clear EN (AUTO=0).
REQ-019 SHALL copy TLOAD into TCOUNT when TLOAD is written while EN=0; a TLOAD write while EN=1 affects only the next reload.
REQ-020 SHALL clear STAT when TCTRL is written with lane 0 enabled and wdata[2]=1 (write-one-to-clear); a same-cycle expiry SHALL win (STAT stays 1).
REQ-021 SHALL, on a TCTRL write that sets EN in the same cycle TCOUNT==0, not expire until the following cycle.
REQ-022 SHALL drive timer_irq equal to STAT.

Reset
REQ-023 SHALL, on clrn=0, asynchronously clear LED, SEG, TCTRL, TLOAD, TCOUNT and both synchronizer stages; led=0, seg=0, timer_irq=0.
REQ-024 SHALL, on reset asserted mid-count, abandon the count; counting resumes only after software sets EN.

Configuration
REQ-025 SHALL compile the timer (TCTRL/TLOAD/TCOUNT, timer_irq) only when macro MINISYS_IO_TIMER_EN is defined.
REQ-026 SHALL, without MINISYS_IO_TIMER_EN, read offsets 0x0C-0x14 as 0, ignore writes to them, and tie timer_irq to 0.

Structure
REQ-027 SHALL place the IO base byte (8'hff), register offset constants and TCTRL bit positions in the shared package minisys_pkg.
REQ-028 SHALL implement the timer as sub-module minisys_io_timer; decode, lane writes and synchronizer stay in the top.

Verification
REQ-029 SHALL cover: addr=32'hff000000, wdata=32'h00a5a5a5, memwrite=4'b1111 -> led=24'ha5a5a5 next edge; same write at addr=32'h00000000 -> led unchanged, io_sel=0.
REQ-030 SHALL cover: SEG=32'h12345678 then write wdata=32'hffffffff, memwrite=4'b0010 -> seg=32'h1234ff78.
REQ-031 SHALL cover: sw=24'h00f00f -> SW read at 32'hff000008 returns 32'h0000f00f two edges later, 0 before.
REQ-032 SHALL cover: TLOAD=3, TCTRL=1 -> TCOUNT 3,2,1,0, STAT=1 next edge, EN cleared; with TCTRL=3 -> TCOUNT reloads 3, STAT=1.
REQ-033 SHALL cover: W1C of STAT on the expiry cycle -> timer_irq remains 1; W1C one cycle later -> timer_irq=0.
REQ-034 SHALL cover: clrn pulsed low mid-count (TCOUNT=2) -> all outputs 0 immediately, no expiry afterward.
